seq_timer_ctrl: RTL and testbench
=================================

SEQ_TIMER_CTRL -- requirements
Module: seq_timer_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SHOW_TICKS, 2, ticks each sequence element is shown; legal range 1..255.
- GAP_TICKS, 1, blank ticks between shown elements; legal range 1..255.
- TIMEOUT_TICKS, 8, ticks the user has per entry; legal range 1..255.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLOCK  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle timebase strobe from the clock divider.
- start  in  1  begin a round; sampled in IDLE only.
- abort  in  1  synchronous return to IDLE from any state.
- level  in  4  round length minus one; element count = level+1 (1..16).
- key_valid  in  1  one-cycle strobe per confirmed user entry.
- addr  out  4  sequence index driven to the sequence memory and comparator.
- show_en  out  1  high while element addr is displayed.
- end_FPGA  out  1  one-cycle pulse: playback finished.
- end_User  out  1  one-cycle pulse: all user entries received.
- end_time  out  1  one-cycle pulse: user entry timed out.
- busy  out  1  high in any state other than IDLE.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, SHOW, GAP and USER.

REQ-005 IDLE:
- on start=1, latch level into len, clear addr and tick_cnt, and go to SHOW next cycle.
- show_en rises one cycle after start is sampled.

REQ-006 SHOW:
- show_en=1.
- tick_cnt increments on each tick.
- on a tick with tick_cnt==SHOW_TICKS-1, clear tick_cnt and go to GAP.

REQ-007 GAP:
- show_en=0.
- on a tick with tick_cnt==GAP_TICKS-1: if addr==len, set addr=0, pulse end_FPGA and go to USER; otherwise increment addr, clear tick_cnt and go to SHOW.

REQ-008 USER, on key_valid:
- clear tick_cnt.
- if addr==len, pulse end_User and go to IDLE; otherwise increment addr.

REQ-009 USER, on a tick with tick_cnt==TIMEOUT_TICKS-1 and no key_valid: pulse end_time and go to IDLE.

REQ-010 When key_valid and the timeout tick occur in the same cycle, key_valid SHALL win; the timeout counter restarts.

REQ-011 start while busy=1 SHALL be ignored; level changes while busy=1 SHALL have no effect, because len is latched.

REQ-012 key_valid outside USER SHALL be ignored.

REQ-013 tick_cnt SHALL be 8 bits and never exceed its parameter minus one; addr SHALL never exceed len.

REQ-014 abort=1 SHALL force IDLE on the next edge:
- addr=0, show_en=0, no end pulse.
- abort has priority over all other inputs.

REQ-015 end_FPGA, end_User and end_time SHALL each be exactly one cycle wide and mutually exclusive.

Reset
REQ-016 reset=1 SHALL asynchronously force:
- state IDLE, addr=0, len=0, tick_cnt=0.
- show_en=0, end_FPGA=0, end_User=0, end_time=0, busy=0.

REQ-017 Reset asserted mid-round SHALL abandon the round with no end pulse; operation resumes only on a new start after release.

Verification
REQ-018 The bench SHALL cover at least these directed scenarios (SHOW_TICKS=2, GAP_TICKS=1, TIMEOUT_TICKS=3, tick held at 1 unless stated):
- Playback: level=1, start at cycle 0 -> show_en high cycles 1-2 (addr=0) and 4-5 (addr=1); end_FPGA pulse at cycle 7 with addr=0, busy=1.
- Full user pass: after playback, key_valid on two cycles two apart -> addr 0->1; end_User pulse one cycle after the second key; busy=0 the following cycle.
- Timeout: no key_valid after playback -> end_time pulse 3 ticks after USER entry; no end_User.
- Simultaneous: key_valid on the timeout tick -> no end_time, addr increments, timeout restarts.
- Abort and reset: abort in SHOW -> IDLE next cycle, show_en=0, no pulses; reset in USER -> all outputs 0 immediately, without waiting for a clock edge.
- Ignored inputs: start during GAP -> no effect; level=15 with a slow tick (every 4th cycle) -> addr walks 0..15, then end_FPGA.

Source files
------------

// File: rtl/seq_timer_ctrl.sv
// Round sequencer for a memory game: plays back level+1 elements on a tick timebase,
// then collects one user entry per element, with a per-entry timeout.
module seq_timer_ctrl #(
    parameter int SHOW_TICKS    = 2,
    parameter int GAP_TICKS     = 1,
    parameter int TIMEOUT_TICKS = 8
) (
    input  logic       CLOCK,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] level,
    input  logic       key_valid,
    output logic [3:0] addr,
    output logic       show_en,
    output logic       end_FPGA,
    output logic       end_User,
    output logic       end_time,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        USER = 2'd3
    } state_t;

    localparam logic [7:0] SHOW_LAST    = 8'(SHOW_TICKS - 1);
    localparam logic [7:0] GAP_LAST     = 8'(GAP_TICKS - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_TICKS - 1);

    state_t     state_reg;
    logic [3:0] len_reg;
    logic [7:0] tick_cnt_reg;

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            len_reg      <= 4'd0;
            tick_cnt_reg <= 8'd0;
            addr         <= 4'd0;
            show_en      <= 1'b0;
            end_FPGA     <= 1'b0;
            end_User     <= 1'b0;
            end_time     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            end_FPGA <= 1'b0;
            end_User <= 1'b0;
            end_time <= 1'b0;
            if (abort) begin
                state_reg    <= IDLE;
                tick_cnt_reg <= 8'd0;
                addr         <= 4'd0;
                show_en      <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            len_reg      <= level;
                            addr         <= 4'd0;
                            tick_cnt_reg <= 8'd0;
                            state_reg    <= SHOW;
                            show_en      <= 1'b1;
                            busy         <= 1'b1;
                        end
                    end
                    SHOW: begin
                        if (tick) begin
                            if (tick_cnt_reg == SHOW_LAST) begin
                                tick_cnt_reg <= 8'd0;
                                state_reg    <= GAP;
                                show_en      <= 1'b0;
                            end else begin
                                tick_cnt_reg <= tick_cnt_reg + 8'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            if (tick_cnt_reg == GAP_LAST) begin
                                tick_cnt_reg <= 8'd0;
                                if (addr == len_reg) begin
                                    addr      <= 4'd0;
                                    end_FPGA  <= 1'b1;
                                    state_reg <= USER;
                                end else begin
                                    addr      <= addr + 4'd1;
                                    state_reg <= SHOW;
                                    show_en   <= 1'b1;
                                end
                            end else begin
                                tick_cnt_reg <= tick_cnt_reg + 8'd1;
                            end
                        end
                    end
                    USER: begin
                        // An entry always beats a coincident timeout tick and restarts the window.
                        if (key_valid) begin
                            tick_cnt_reg <= 8'd0;
                            if (addr == len_reg) begin
                                end_User  <= 1'b1;
                                state_reg <= IDLE;
                                addr      <= 4'd0;
                                busy      <= 1'b0;
                            end else begin
                                addr <= addr + 4'd1;
                            end
                        end else if (tick) begin
                            if (tick_cnt_reg == TIMEOUT_LAST) begin
                                end_time     <= 1'b1;
                                state_reg    <= IDLE;
                                tick_cnt_reg <= 8'd0;
                                addr         <= 4'd0;
                                busy         <= 1'b0;
                            end else begin
                                tick_cnt_reg <= tick_cnt_reg + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_reg    <= IDLE;
                        tick_cnt_reg <= 8'd0;
                        addr         <= 4'd0;
                        show_en      <= 1'b0;
                        busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_timer_ctrl.sv
// Scoreboard bench for seq_timer_ctrl: directed scenarios plus random rounds against a
// tick-counting reference model of a whole round.
module tb_seq_timer_ctrl;

    localparam int S = 2;
    localparam int G = 1;
    localparam int T = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] level = 4'd0;
    logic       key_valid = 1'b0;
    logic [3:0] addr;
    logic       show_en, end_FPGA, end_User, end_time, busy;

    seq_timer_ctrl #(
        .SHOW_TICKS(S),
        .GAP_TICKS(G),
        .TIMEOUT_TICKS(T)
    ) dut (
        .CLOCK(clk),
        .reset(reset),
        .tick(tick),
        .start(start),
        .abort(abort),
        .level(level),
        .key_valid(key_valid),
        .addr(addr),
        .show_en(show_en),
        .end_FPGA(end_FPGA),
        .end_User(end_User),
        .end_time(end_time),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] addr;
        logic       show_en;
        logic       busy;
        logic       e_fpga;
        logic       e_user;
        logic       e_time;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a round is a count of ticks (playback) or entries (user phase).
    int   m_phase, m_len, m_play, m_keys, m_wait;
    obs_t m_obs;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {addr, show_en, busy, end_FPGA, end_User, end_time};
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_bad++;
                $display("FAIL scoreboard t=%0t got addr=%0d show=%b busy=%b fpga=%b user=%b time=%b, want addr=%0d show=%b busy=%b fpga=%b user=%b time=%b",
                         $time, mon_a.addr, mon_a.show_en, mon_a.busy, mon_a.e_fpga, mon_a.e_user, mon_a.e_time,
                         mon_e.addr, mon_e.show_en, mon_e.busy, mon_e.e_fpga, mon_e.e_user, mon_e.e_time);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_len = 0; m_play = 0; m_keys = 0; m_wait = 0;
        m_obs = '0;
    endtask

    task automatic model_step(input logic t, input logic s, input logic a,
                              input logic [3:0] lv, input logic k);
        m_obs.e_fpga = 1'b0;
        m_obs.e_user = 1'b0;
        m_obs.e_time = 1'b0;
        if (a) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (s) begin
                    m_phase = 1; m_len = int'(lv); m_play = 0;
                end
                1: if (t) begin
                    m_play++;
                    if (m_play == (m_len + 1) * (S + G)) begin
                        m_phase = 2; m_keys = 0; m_wait = 0; m_obs.e_fpga = 1'b1;
                    end
                end
                2: if (k) begin
                    m_keys++;
                    m_wait = 0;
                    if (m_keys == m_len + 1) begin
                        m_phase = 0; m_obs.e_user = 1'b1;
                    end
                end else if (t) begin
                    m_wait++;
                    if (m_wait == T) begin
                        m_phase = 0; m_obs.e_time = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        case (m_phase)
            1: begin
                m_obs.addr    = 4'(m_play / (S + G));
                m_obs.show_en = (m_play % (S + G)) < S;
                m_obs.busy    = 1'b1;
            end
            2: begin
                m_obs.addr    = 4'(m_keys);
                m_obs.show_en = 1'b0;
                m_obs.busy    = 1'b1;
            end
            default: begin
                m_obs.addr    = 4'd0;
                m_obs.show_en = 1'b0;
                m_obs.busy    = 1'b0;
            end
        endcase
    endtask

    // Drive one cycle of inputs; expectation for the following cycle goes to the scoreboard.
    task automatic step(input logic t, input logic s, input logic a,
                        input logic [3:0] lv, input logic k);
        tick = t; start = s; abort = a; level = lv; key_valid = k;
        model_step(t, s, a, lv, k);
        @(posedge clk);
        #1;
        exp_q.push_back(m_obs);
    endtask

    // Level-1 playback starting in cycle 0; returns in cycle 7 (first USER cycle).
    task automatic playback(input bit poke_gap);
        logic [7:1] show_pat;
        logic [7:1] addr_pat;
        logic       poke;
        show_pat = 7'b0011011;
        addr_pat = 7'b0111000;
        step(1, 1, 0, 4'd1, 0);
        for (int c = 1; c <= 7; c++) begin
            check("pb_show_en", show_en, show_pat[c]);
            check("pb_addr", addr, addr_pat[c]);
            check("pb_busy", busy, 1);
            check("pb_end_FPGA", end_FPGA, c == 7);
            if (c < 7) begin
                poke = poke_gap && (c == 3);
                step(1, poke, 0, poke ? 4'd3 : 4'd1, 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int   max_addr;
        bit   seen_end;
        logic t, s, a, k;
        logic [3:0] lv;

        model_reset();
        #1 reset = 1'b1;
        #1;
        check("reset_busy", busy, 0);
        check("reset_addr", addr, 0);
        check("reset_show_en", show_en, 0);
        check("reset_pulses", {end_FPGA, end_User, end_time}, 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Playback, then a full user pass with keys two cycles apart.
        playback(0);
        step(1, 0, 0, 4'd1, 1);
        check("user_addr_after_key", addr, 1);
        check("user_no_early_end", end_User, 0);
        step(1, 0, 0, 4'd1, 0);
        step(1, 0, 0, 4'd1, 1);
        check("user_end_User", end_User, 1);
        check("user_busy_drop", busy, 0);
        step(0, 0, 0, 4'd1, 0);
        check("user_end_User_width", end_User, 0);
        check("user_busy_idle", busy, 0);

        // Timeout three ticks after USER entry.
        playback(0);
        for (int c = 8; c <= 10; c++) begin
            step(1, 0, 0, 4'd1, 0);
            check("timeout_end_time", end_time, c == 10);
            check("timeout_no_end_User", end_User, 0);
        end

        // Key on the timeout tick wins and restarts the window.
        playback(0);
        step(1, 0, 0, 4'd1, 0);
        step(1, 0, 0, 4'd1, 0);
        step(1, 0, 0, 4'd1, 1);
        check("simul_no_end_time", end_time, 0);
        check("simul_addr", addr, 1);
        check("simul_busy", busy, 1);
        step(1, 0, 0, 4'd1, 0);
        step(1, 0, 0, 4'd1, 0);
        check("simul_restart_wait", end_time, 0);
        step(1, 0, 0, 4'd1, 0);
        check("simul_end_time", end_time, 1);

        // Abort during SHOW.
        step(1, 1, 0, 4'd2, 0);
        check("abort_pre_show", show_en, 1);
        step(1, 0, 1, 4'd2, 0);
        check("abort_show_en", show_en, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", addr, 0);
        check("abort_pulses", {end_FPGA, end_User, end_time}, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 4'd2, 0);

        // Asynchronous reset in USER.
        playback(0);
        @(negedge clk);
        #1;
        tick = 1'b0; start = 1'b0; key_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_user_busy", busy, 0);
        check("rst_user_addr", addr, 0);
        check("rst_user_pulses", {end_FPGA, end_User, end_time}, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 4'd1, 1);
        check("rst_stays_idle", busy, 0);

        // start during GAP is ignored.
        playback(1);
        step(1, 0, 1, 4'd0, 0);

        // level=15 with a slow tick; level wiggles are ignored once latched.
        step(0, 1, 0, 4'd15, 0);
        max_addr = 0;
        seen_end = 1'b0;
        for (int i = 0; i < 400 && !seen_end; i++) begin
            step((i % 4) == 3, 0, 0, 4'($urandom_range(0, 15)), 0);
            if (busy && show_en && int'(addr) > max_addr) max_addr = int'(addr);
            if (end_FPGA) seen_end = 1'b1;
        end
        check("slow_max_addr", 8'(max_addr), 15);
        check("slow_end_FPGA_seen", seen_end, 1);
        step(1, 0, 1, 4'd0, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            t  = $urandom_range(0, 1);
            s  = ($urandom_range(0, 7) == 0);
            a  = ($urandom_range(0, 99) == 0);
            k  = ($urandom_range(0, 3) == 0);
            lv = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            step(t, s, a, lv, k);
        end

        step(0, 0, 1, 4'd0, 0);
        step(0, 0, 0, 4'd0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 8'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
